// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART TX packet arbiter.
// UART_ARB_ID_HDR_EN adds a requester-id header byte per packet.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_LOAD = 2'd2,
    ST_WAIT = 2'd3
  } arb_state_e;

  localparam logic [3:0] HDR_MAGIC         = 4'hA;
  localparam logic [2:0] BAUD_CODE_DEFAULT = 3'd0;

  function automatic logic [7:0] hdr_byte(
    input logic [3:0] id
  );
    return {HDR_MAGIC, id};
  endfunction

endpackage

// File: rtl/uart_arb_if.sv
// Byte-stream bundle from the requesters into the arbiter.
// master: requester side, slave: arbiter side.
interface uart_arb_if #(
  parameter int NUM_REQ = 4
) ();

  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;

  modport master (
    output req_valid,
    output req_data,
    output req_last,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  req_last,
    output req_ready
  );

endinterface

// File: rtl/uart_rr_picker.sv
// Round-robin picker: first set request bit above ptr_i,
// wrapping modulo NUM_REQ.
module uart_rr_picker
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     ptr_i,
  output logic               any_o,
  output logic [IDW-1:0]     idx_o
);

  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!any_o && req_i[(int'(ptr_i) + i) % NUM_REQ]) begin
        any_o = 1'b1;
        idx_o = IDW'((int'(ptr_i) + i) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet round-robin arbiter sharing one UART byte transmitter.
// Optional id header byte with UART_ARB_ID_HDR_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_arb_if.slave      req,
  input  logic [2:0]     cfg_baud_sel,
  output logic [2:0]     baud_sel,
  output logic [7:0]     tx_data,
  output logic           tx_req,
  input  logic           tx_busy,
  input  logic           tx_done,
  output logic           grant_vld,
  output logic [IDW-1:0] grant_id,
  output logic           pkt_done
);

  arb_state_e     state_q;
  logic [2:0]     baud_q;
  logic [7:0]     data_q;
  logic           txreq_q;
  logic           gvld_q;
  logic [IDW-1:0] gid_q;
  logic           pdone_q;
  logic           last_q;
  logic [IDW-1:0] ptr_q;

  logic           any_w;
  logic [IDW-1:0] win_w;
  logic [7:0]     gnt_byte;
  logic           gnt_last;
  logic           hs;

  uart_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_pick (
    .req_i (req.req_valid),
    .ptr_i (ptr_q),
    .any_o (any_w),
    .idx_o (win_w)
  );

  assign gnt_byte = req.req_data[{gid_q, 3'b000} +: 8];
  assign gnt_last = req.req_last[gid_q];

  // Byte accepted only when the transmitter is free.
  assign hs = (state_q == ST_LOAD) && !tx_busy
           && req.req_valid[gid_q];

  always_comb begin
    req.req_ready        = '0;
    req.req_ready[gid_q] = hs;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      baud_q  <= BAUD_CODE_DEFAULT;
      data_q  <= '0;
      txreq_q <= 1'b0;
      gvld_q  <= 1'b0;
      gid_q   <= '0;
      pdone_q <= 1'b0;
      last_q  <= 1'b0;
      ptr_q   <= IDW'(NUM_REQ - 1);
    end else begin
      txreq_q <= 1'b0;
      pdone_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          baud_q <= cfg_baud_sel;
          if (any_w) begin
            gid_q  <= win_w;
            gvld_q <= 1'b1;
`ifdef UART_ARB_ID_HDR_EN
            state_q <= ST_HDR;
`else
            state_q <= ST_LOAD;
`endif
          end
        end
`ifdef UART_ARB_ID_HDR_EN
        // Header frame reuses WAIT; last_q=0 returns to LOAD.
        ST_HDR: begin
          if (!tx_busy) begin
            data_q  <= hdr_byte(4'(gid_q));
            last_q  <= 1'b0;
            txreq_q <= 1'b1;
            state_q <= ST_WAIT;
          end
        end
`endif
        ST_LOAD: begin
          if (hs) begin
            data_q  <= gnt_byte;
            last_q  <= gnt_last;
            txreq_q <= 1'b1;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (tx_done) begin
            if (last_q) begin
              pdone_q <= 1'b1;
              ptr_q   <= gid_q;
              gvld_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_LOAD;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign baud_sel  = baud_q;
  assign tx_data   = data_q;
  assign tx_req    = txreq_q;
  assign grant_vld = gvld_q;
  assign grant_id  = gid_q;
  assign pkt_done  = pdone_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple
// transmitter model and per-requester byte FIFOs.
module tb_uart_tx_arbiter;

  localparam int NR    = 4;
  localparam int FRAME = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] cfg_baud_sel = 3'd0;
  logic [2:0] baud_sel;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       tx_busy;
  logic       tx_done;
  logic       grant_vld;
  logic [1:0] grant_id;
  logic       pkt_done;

  always #10 clk = ~clk;

  uart_arb_if #(.NUM_REQ(NR)) rif ();

  uart_tx_arbiter #(.NUM_REQ(NR)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (rif.slave),
    .cfg_baud_sel (cfg_baud_sel),
    .baud_sel     (baud_sel),
    .tx_data      (tx_data),
    .tx_req       (tx_req),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done),
    .grant_vld    (grant_vld),
    .grant_id     (grant_id),
    .pkt_done     (pkt_done)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [8:0]    mem [NR][32];
  int            hd [NR];
  int            tl [NR];
  logic [NR-1:0] stall = '0;

  int ev_id [64];
  int ev_data [64];
  int ev_baud [64];
  int ev_cyc [64];
  int nev, npkt, viol, cyc, cnt;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      logic [8:0] e;
      e = mem[i][hd[i] % 32];
      rif.req_valid[i]       = (hd[i] < tl[i]) && !stall[i];
      rif.req_data[i*8 +: 8] = e[7:0];
      rif.req_last[i]        = e[8];
    end
  endtask

  // Requester FIFOs, transmitter model and tx_req logger.
  initial begin
    logic sreq;
    tx_busy = 1'b0;
    tx_done = 1'b0;
    cnt = 0; cyc = 0; nev = 0; npkt = 0; viol = 0;
    for (int i = 0; i < NR; i++) hd[i] = 0;
    rif.req_valid = '0;
    rif.req_data  = '0;
    rif.req_last  = '0;
    forever begin
      @(posedge clk);
      cyc++;
      sreq = 1'b0;
      if (!rst_n) begin
        for (int i = 0; i < NR; i++) hd[i] = 0;
        nev = 0; npkt = 0; viol = 0;
      end else begin
        for (int i = 0; i < NR; i++)
          if (rif.req_valid[i] && rif.req_ready[i]) hd[i]++;
        if (tx_req) begin
          if (nev < 64) begin
            ev_id[nev]   = int'(grant_id);
            ev_data[nev] = int'(tx_data);
            ev_baud[nev] = int'(baud_sel);
            ev_cyc[nev]  = cyc;
          end
          nev++;
          if (tx_busy) viol++;
          sreq = 1'b1;
        end
        if (pkt_done) npkt++;
      end
      #1;
      if (!rst_n) begin
        tx_busy = 1'b0;
        cnt = 0;
      end else if (sreq) begin
        tx_busy = 1'b1;
        cnt = FRAME;
      end else if (tx_busy) begin
        cnt--;
        if (cnt == 0) tx_busy = 1'b0;
      end
      tx_done = tx_busy && (cnt == 1);
      drive();
    end
  end

  task automatic push(input int r, input logic [7:0] d,
                      input logic l);
    mem[r][tl[r]] = {l, d};
    tl[r]++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    stall = '0;
    for (int i = 0; i < NR; i++) tl[i] = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_ev(input int n, input int budget);
    int k = 0;
    while (nev < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (nev < n) chk("timeout_ev", nev, n);
  endtask

  function automatic logic drained();
    logic d = 1'b1;
    for (int i = 0; i < NR; i++)
      if (hd[i] < tl[i]) d = 1'b0;
    return d && !grant_vld && !tx_busy;
  endfunction

  task automatic wait_idle(input int budget);
    int k = 0;
    while (!drained() && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!drained()) chk("timeout_idle", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < NR; i++) tl[i] = 0;
    cfg_baud_sel = 3'd3;
    do_reset();
    chk("rst_tx_req", tx_req, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_grant_vld", grant_vld, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_pkt_done", pkt_done, 0);
    chk("rst_ready", rif.req_ready, 0);

`ifdef UART_ARB_ID_HDR_EN
    push(3, 8'h5C, 1'b1);
    wait_idle(2000);
    chk("hdr_n", nev, 2);
    chk("hdr_b0", ev_data[0], 32'hA3);
    chk("hdr_b1", ev_data[1], 32'h5C);
    chk("hdr_id0", ev_id[0], 3);
    chk("hdr_id1", ev_id[1], 3);
    chk("hdr_pkt", npkt, 1);
    chk("hdr_viol", viol, 0);
`else
    // Single requester, 3-byte packet.
    cfg_baud_sel = 3'd5;
    @(negedge clk);
    push(1, 8'h11, 1'b0);
    push(1, 8'h22, 1'b0);
    push(1, 8'h33, 1'b1);
    wait_idle(2000);
    chk("t1_n", nev, 3);
    chk("t1_b0", ev_data[0], 32'h11);
    chk("t1_b1", ev_data[1], 32'h22);
    chk("t1_b2", ev_data[2], 32'h33);
    chk("t1_id0", ev_id[0], 1);
    chk("t1_id2", ev_id[2], 1);
    chk("t1_baud", ev_baud[0], 5);
    chk("t1_gap", ev_cyc[1] - ev_cyc[0], FRAME + 2);
    chk("t1_pkt", npkt, 1);
    chk("t1_viol", viol, 0);

    // All four valid: 0,1,2,3 then 0 again.
    do_reset();
    push(0, 8'hA0, 1'b1);
    push(0, 8'hB0, 1'b1);
    push(1, 8'hA1, 1'b1);
    push(2, 8'hA2, 1'b1);
    push(3, 8'hA3, 1'b1);
    wait_idle(3000);
    chk("t2_n", nev, 5);
    chk("t2_id0", ev_id[0], 0);
    chk("t2_id1", ev_id[1], 1);
    chk("t2_id2", ev_id[2], 2);
    chk("t2_id3", ev_id[3], 3);
    chk("t2_id4", ev_id[4], 0);
    chk("t2_b4", ev_data[4], 32'hB0);
    chk("t2_pkt", npkt, 5);

    // Requester 2 stalls mid-packet.
    do_reset();
    push(2, 8'h21, 1'b0);
    push(2, 8'h22, 1'b0);
    push(2, 8'h23, 1'b1);
    wait_ev(1, 200);
    stall[2] = 1'b1;
    push(0, 8'h0F, 1'b1);
    push(3, 8'h3F, 1'b1);
    repeat (500) @(negedge clk);
    chk("t3_stall_n", nev, 1);
    chk("t3_stall_gid", grant_id, 2);
    chk("t3_stall_gv", grant_vld, 1);
    stall[2] = 1'b0;
    wait_idle(3000);
    chk("t3_n", nev, 5);
    chk("t3_b1", ev_data[1], 32'h22);
    chk("t3_b2", ev_data[2], 32'h23);
    chk("t3_id3", ev_id[3], 3);
    chk("t3_id4", ev_id[4], 0);
    chk("t3_pkt", npkt, 3);
    chk("t3_viol", viol, 0);

    // Baud change mid-packet.
    cfg_baud_sel = 3'd4;
    do_reset();
    push(1, 8'h41, 1'b0);
    push(1, 8'h42, 1'b1);
    wait_ev(1, 200);
    cfg_baud_sel = 3'd0;
    push(2, 8'h51, 1'b1);
    repeat (3) @(negedge clk);
    chk("t4_hold", baud_sel, 4);
    wait_idle(3000);
    chk("t4_baud0", ev_baud[0], 4);
    chk("t4_baud1", ev_baud[1], 4);
    chk("t4_baud2", ev_baud[2], 0);
    chk("t4_id2", ev_id[2], 2);
`endif

    // Async reset during WAIT, then priority restart.
    cfg_baud_sel = 3'd6;
    do_reset();
    push(1, 8'h61, 1'b0);
    push(1, 8'h62, 1'b1);
    wait_ev(1, 400);
    repeat (3) @(negedge clk);
    chk("t5_pre_baud", baud_sel, 6);
    chk("t5_pre_gid", grant_id, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_gv", grant_vld, 0);
    chk("t5_gid", grant_id, 0);
    chk("t5_data", tx_data, 0);
    chk("t5_baud", baud_sel, 0);
    chk("t5_req", tx_req, 0);
    chk("t5_pd", pkt_done, 0);
    stall = '0;
    for (int i = 0; i < NR; i++) tl[i] = 0;
    repeat (2) @(negedge clk);
    push(0, 8'h70, 1'b1);
    push(3, 8'h73, 1'b1);
    rst_n = 1'b1;
    wait_idle(3000);
    chk("t5_id0", ev_id[0], 0);
`ifdef UART_ARB_ID_HDR_EN
    chk("t5_b1", ev_data[1], 32'h70);
    chk("t5_id2", ev_id[2], 3);
`else
    chk("t5_b0", ev_data[0], 32'h70);
    chk("t5_id1", ev_id[1], 3);
`endif
    chk("t5_viol", viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
